// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT scheduler: FSM encoding, timeout length and HI/LO selects.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_CYCLES = 64;
    localparam int unsigned TMO_W          = 7;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    function automatic logic [31:0] hilo_pick(input logic sel,
                                              input logic [31:0] hi,
                                              input logic [31:0] lo);
        return (sel == SEL_HI) ? hi : lo;
    endfunction

endpackage

// File: rtl/muldiv_scheduler_if.sv
// Bundle of the CPU request, multiplier and HI/LO access signals around the MULT scheduler.
interface muldiv_scheduler_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_valid;
    logic [63:0] mul_product;
    logic        mul_abort;

    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        wr_en;
    logic        wr_sel;
    logic [31:0] wr_data;
    logic        stall;

    logic        busy;
    logic        err;

    modport slave (
        input  req_valid, op_a, op_b, mul_valid, mul_product,
               rd_req, rd_sel, wr_en, wr_sel, wr_data,
        output req_ready, mul_start, mul_a, mul_b, mul_abort,
               rd_data, stall, busy, err
    );

    modport master (
        output req_valid, op_a, op_b, mul_valid, mul_product,
               rd_req, rd_sel, wr_en, wr_sel, wr_data,
        input  req_ready, mul_start, mul_a, mul_b, mul_abort,
               rd_data, stall, busy, err
    );

endinterface

// File: rtl/hilo_regfile.sv
// HI/LO register pair with a registered read port, a CPU write port and a 64-bit product load.
module hilo_regfile
    import muldiv_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        rd_en,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [31:0] wr_data,
    input  logic        load_en,
    input  logic [63:0] load_value
);

    logic [31:0] hi;
    logic [31:0] lo;

    // NOTE: non-blocking updates let a read and a write to the same register on one edge return the old value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hi      <= '0;
            lo      <= '0;
            rd_data <= '0;
        end else begin
            if (rd_en) begin
                rd_data <= hilo_pick(rd_sel, hi, lo);
            end
            if (load_en) begin
                hi <= load_value[63:32];
                lo <= load_value[31:0];
            end else if (wr_en) begin
                if (wr_sel == SEL_HI) begin
                    hi <= wr_data;
                end else begin
                    lo <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/muldiv_scheduler.sv
// Sequences one MULT through the Booth multiplier and owns HI/LO access while it is in flight.
// Optional feature: define MUL_TIMEOUT_EN to bound WAIT and abort a hung multiplier.
module muldiv_scheduler
    import muldiv_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    muldiv_scheduler_if.slave bus
);

    state_t      state;
    state_t      state_next;
    logic [31:0] mul_a_q;
    logic [31:0] mul_b_q;
    logic [63:0] product_q;
    logic        req_ready_c;
    logic        mul_start_c;
    logic        abort_c;
    logic        take_result;
    logic        busy_c;
    logic [31:0] rd_data_w;

`ifdef MUL_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             err_q;

    // Fires on the WAIT cycle whose increment would bring the count to TIMEOUT_CYCLES.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        req_ready_c = 1'b0;
        mul_start_c = 1'b0;
        abort_c     = 1'b0;
        take_result = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mul_start_c = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                if (bus.mul_valid) begin
                    take_result = 1'b1;
                    state_next  = WRITE;
                end
`ifdef MUL_TIMEOUT_EN
                else if (tmo_hit) begin
                    abort_c    = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            product_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.req_valid) begin
                mul_a_q <= bus.op_a;
                mul_b_q <= bus.op_b;
            end
            if (take_result) begin
                product_q <= bus.mul_product;
            end
        end
    end

`ifdef MUL_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (abort_c) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // CPU accesses are blocked for the whole operation, including the WRITE cycle.
    assign busy_c = (state != IDLE);

    hilo_regfile u_hilo (
        .CLK        (CLK),
        .RST        (RST),
        .rd_en      (bus.rd_req & ~busy_c),
        .rd_sel     (bus.rd_sel),
        .rd_data    (rd_data_w),
        .wr_en      (bus.wr_en & ~busy_c),
        .wr_sel     (bus.wr_sel),
        .wr_data    (bus.wr_data),
        .load_en    (state == WRITE),
        .load_value (product_q)
    );

    assign bus.req_ready = req_ready_c;
    assign bus.mul_start = mul_start_c;
    assign bus.mul_abort = abort_c;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rd_data   = rd_data_w;
    assign bus.busy      = busy_c;
    assign bus.stall     = (bus.rd_req | bus.wr_en) & busy_c;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed scoreboard bench for muldiv_scheduler; covers both MUL_TIMEOUT_EN builds.
module tb_muldiv_scheduler;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } op_pair_t;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    logic [31:0] rd_q[$];
    op_pair_t    start_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    logic        rd_pending;

    muldiv_scheduler_if ifc ();

    muldiv_scheduler dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with no expectation queued (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive a read this cycle; its data is compared by the monitor one cycle later.
    task automatic do_read(input logic sel, input logic [31:0] expected);
        ifc.rd_req = 1'b1;
        ifc.rd_sel = sel;
        rd_q.push_back(expected);
        @(negedge CLK);
        check("read_no_stall", ifc.stall, 1'b0);
        check("read_not_busy", ifc.busy, 1'b0);
        tick();
        ifc.rd_req = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        ifc.req_valid = 1'b1;
        ifc.op_a      = a;
        ifc.op_b      = b;
        start_q.push_back('{a: a, b: b});
        @(negedge CLK);
        check("issue_req_ready", ifc.req_ready, 1'b1);
        tick();
        ifc.req_valid = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents read data or a start pulse.
    always @(negedge CLK) begin
        op_pair_t e;
        if (rd_pending) begin
            if (rd_q.size() == 0) begin
                flag("rd_data_unexpected");
            end else begin
                check("rd_data", ifc.rd_data, rd_q.pop_front());
            end
        end
        rd_pending = ifc.rd_req && !ifc.stall && !RST;
        if (ifc.mul_start) begin
            if (start_q.size() == 0) begin
                flag("mul_start_unexpected");
            end else begin
                e = start_q.pop_front();
                check("mul_a_at_start", ifc.mul_a, e.a);
                check("mul_b_at_start", ifc.mul_b, e.b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  abort_at;
        logic abort_seen;
        checks = 0;
        errors = 0;
        rd_pending = 1'b0;
        model_hi = '0;
        model_lo = '0;
        RST = 1'b1;
        ifc.req_valid = 1'b0; ifc.op_a = '0; ifc.op_b = '0;
        ifc.mul_valid = 1'b0; ifc.mul_product = '0;
        ifc.rd_req = 1'b0; ifc.rd_sel = 1'b0;
        ifc.wr_en = 1'b0; ifc.wr_sel = 1'b0; ifc.wr_data = '0;

        // Reset state
        tick();
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_req_ready", ifc.req_ready, 1'b1);
        check("rst_busy", ifc.busy, 1'b0);
        check("rst_stall", ifc.stall, 1'b0);
        check("rst_mul_start", ifc.mul_start, 1'b0);
        check("rst_mul_abort", ifc.mul_abort, 1'b0);
        check("rst_err", ifc.err, 1'b0);
        check("rst_mul_a", ifc.mul_a, 32'h0);
        check("rst_rd_data", ifc.rd_data, 32'h0);
        tick();
        do_read(1'b1, 32'h0);
        do_read(1'b0, 32'h0);

        // 7 * -3 = -21, mul_valid three cycles after accept
        issue(32'd7, 32'hFFFF_FFFD);
        @(negedge CLK);
        check("c1_mul_start", ifc.mul_start, 1'b1);
        check("c1_busy", ifc.busy, 1'b1);
        check("c1_req_ready", ifc.req_ready, 1'b0);
        tick();
        @(negedge CLK);
        check("c2_mul_start_one_cycle", ifc.mul_start, 1'b0);
        check("c2_busy", ifc.busy, 1'b1);
        tick();
        ifc.mul_valid   = 1'b1;
        ifc.mul_product = 64'hFFFF_FFFF_FFFF_FFEB;
        @(negedge CLK);
        check("c3_mul_a_held", ifc.mul_a, 32'd7);
        tick();
        ifc.mul_valid = 1'b0;
        @(negedge CLK);
        check("c4_write_busy", ifc.busy, 1'b1);
        tick();
        model_hi = 32'hFFFF_FFFF;
        model_lo = 32'hFFFF_FFEB;
        do_read(1'b1, model_hi);
        do_read(1'b0, model_lo);

        // mul_valid in IDLE is ignored
        ifc.mul_valid   = 1'b1;
        ifc.mul_product = 64'h1111_2222_3333_4444;
        tick();
        ifc.mul_valid = 1'b0;
        @(negedge CLK);
        check("stray_valid_busy", ifc.busy, 1'b0);
        check("stray_valid_ready", ifc.req_ready, 1'b1);
        tick();

        // Write LO, read it back; then simultaneous read/write of LO
        ifc.wr_en = 1'b1; ifc.wr_sel = 1'b0; ifc.wr_data = 32'h0000_1234;
        @(negedge CLK);
        check("wr_no_stall", ifc.stall, 1'b0);
        tick();
        ifc.wr_en = 1'b0;
        model_lo = 32'h0000_1234;
        do_read(1'b0, model_lo);
        ifc.wr_en = 1'b1; ifc.wr_sel = 1'b0; ifc.wr_data = 32'h0000_ABCD;
        do_read(1'b0, model_lo);
        ifc.wr_en = 1'b0;
        model_lo = 32'h0000_ABCD;
        do_read(1'b0, model_lo);
        do_read(1'b1, model_hi);

        // Read and second request during WAIT: both held until IDLE
        issue(32'h0001_0000, 32'h0001_0000);
        tick();
        ifc.rd_req = 1'b1; ifc.rd_sel = 1'b1;
        ifc.req_valid = 1'b1; ifc.op_a = 32'hFFFF_FFFE; ifc.op_b = 32'hFFFF_FFFB;
        @(negedge CLK);
        check("wait_stall", ifc.stall, 1'b1);
        check("wait_req_ready", ifc.req_ready, 1'b0);
        tick();
        @(negedge CLK);
        check("wait_stall_2", ifc.stall, 1'b1);
        check("wait_no_restart", ifc.mul_start, 1'b0);
        tick();
        ifc.mul_valid   = 1'b1;
        ifc.mul_product = 64'h0000_0001_0000_0000;
        @(negedge CLK);
        check("valid_cycle_stall", ifc.stall, 1'b1);
        tick();
        ifc.mul_valid = 1'b0;
        @(negedge CLK);
        check("write_stall", ifc.stall, 1'b1);
        check("write_req_ready", ifc.req_ready, 1'b0);
        tick();
        model_hi = 32'h0000_0001;
        model_lo = 32'h0000_0000;
        rd_q.push_back(model_hi);
        start_q.push_back('{a: 32'hFFFF_FFFE, b: 32'hFFFF_FFFB});
        @(negedge CLK);
        check("idle_retry_no_stall", ifc.stall, 1'b0);
        check("idle_second_accept", ifc.req_ready, 1'b1);
        tick();
        ifc.req_valid = 1'b0;
        ifc.rd_req    = 1'b0;
        @(negedge CLK);
        check("second_mul_start", ifc.mul_start, 1'b1);
        tick();
        ifc.mul_valid   = 1'b1;
        ifc.mul_product = 64'd10;
        tick();
        ifc.mul_valid = 1'b0;
        tick();
        model_hi = 32'h0;
        model_lo = 32'd10;
        do_read(1'b0, model_lo);
        do_read(1'b1, model_hi);

`ifdef MUL_TIMEOUT_EN
        // No mul_valid: abort on the 64th WAIT cycle
        issue(32'd3, 32'd4);
        tick();
        abort_at = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            if (ifc.mul_abort) begin
                abort_at = i;
                break;
            end
            tick();
        end
        check("abort_wait_cycle", abort_at, 64);
        tick();
        @(negedge CLK);
        check("abort_one_cycle", ifc.mul_abort, 1'b0);
        check("abort_err", ifc.err, 1'b1);
        check("abort_idle", ifc.busy, 1'b0);
        tick();
        ifc.mul_valid   = 1'b1;
        ifc.mul_product = 64'h0000_0000_0000_0077;
        tick();
        ifc.mul_valid = 1'b0;
        do_read(1'b1, model_hi);
        do_read(1'b0, model_lo);

        // mul_valid on the expiry cycle wins
        issue(32'd8, 32'd9);
        tick();
        repeat (63) tick();
        ifc.mul_valid   = 1'b1;
        ifc.mul_product = 64'd72;
        @(negedge CLK);
        check("expiry_valid_no_abort", ifc.mul_abort, 1'b0);
        tick();
        ifc.mul_valid = 1'b0;
        @(negedge CLK);
        check("expiry_valid_write", ifc.busy, 1'b1);
        check("err_sticky", ifc.err, 1'b1);
        tick();
        model_hi = 32'h0;
        model_lo = 32'd72;
        do_read(1'b1, model_hi);
        do_read(1'b0, model_lo);
`else
        // WAIT is unbounded: 100 idle WAIT cycles, then a normal completion
        issue(32'd3, 32'd4);
        tick();
        abort_seen = 1'b0;
        repeat (100) begin
            @(negedge CLK);
            abort_seen = abort_seen | ifc.mul_abort | ifc.err;
            tick();
        end
        check("long_wait_no_abort", abort_seen, 1'b0);
        check("long_wait_busy", ifc.busy, 1'b1);
        ifc.mul_valid   = 1'b1;
        ifc.mul_product = 64'd12;
        tick();
        ifc.mul_valid = 1'b0;
        tick();
        model_hi = 32'h0;
        model_lo = 32'd12;
        do_read(1'b1, model_hi);
        do_read(1'b0, model_lo);
`endif

        // Reset mid-WAIT, late mul_valid is ignored
        issue(32'd5, 32'd6);
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        ifc.mul_valid   = 1'b1;
        ifc.mul_product = 64'h5;
        @(negedge CLK);
        check("mid_rst_busy", ifc.busy, 1'b0);
        check("mid_rst_ready", ifc.req_ready, 1'b1);
        check("mid_rst_err", ifc.err, 1'b0);
        check("mid_rst_mul_a", ifc.mul_a, 32'h0);
        check("mid_rst_mul_b", ifc.mul_b, 32'h0);
        check("mid_rst_rd_data", ifc.rd_data, 32'h0);
        tick();
        ifc.mul_valid = 1'b0;
        @(negedge CLK);
        check("post_rst_busy", ifc.busy, 1'b0);
        tick();
        model_hi = 32'h0;
        model_lo = 32'h0;
        do_read(1'b1, model_hi);
        do_read(1'b0, model_lo);
        tick();
        tick();

        check("rd_queue_drained", rd_q.size(), 0);
        check("start_queue_drained", start_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_scheduler.md
MULDIV_SCHEDULER -- requirements
Module: muldiv_scheduler

Interface
REQ-001 SHALL have exactly one clock, CLK, and one reset, RST, which is synchronous and active-high.
REQ-002 Ports SHALL be, listed as name, direction, width, meaning:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU control unit issues a MULT.
- req_ready  out  1  scheduler can accept a request.
- op_a, op_b  in  32  signed operands (rs, rt).
- mul_start  out  1  one-cycle start pulse to the Booth multiplier controller.
- mul_a, mul_b  out  32  operands held stable to the multiplier from accept until it finishes.
- mul_valid  in  1  multiplier result ready (one-cycle pulse).
- mul_product  in  64  signed product; sampled only when mul_valid=1.
- mul_abort  out  1  one-cycle pulse that cancels the multiplier.
- rd_req  in  1  MFHI/MFLO read request.
- rd_sel  in  1  read select: 0=LO, 1=HI.
- rd_data  out  32  registered read data.
- wr_en  in  1  MTHI/MTLO write.
- wr_sel  in  1  write select: 0=LO, 1=HI.
- wr_data  in  32  write data.
- stall  out  1  CPU must hold its current rd_req or wr_en.
- busy  out  1  a multiply is in flight.
- err  out  1  sticky timeout flag.

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT, WRITE.
REQ-004 IDLE SHALL assert req_ready=1; when req_valid=1 it SHALL latch op_a/op_b into mul_a/mul_b and move to ISSUE.
REQ-005 ISSUE SHALL assert mul_start=1 for exactly one cycle, then move to WAIT.
REQ-006 WAIT SHALL hold until mul_valid=1, then latch mul_product and move to WRITE.
REQ-007 WRITE SHALL load HI=product[63:32] and LO=product[31:0], then return to IDLE.
REQ-008 Latency: accept at cycle 0, mul_start at cycle 1; HI/LO are valid 2 cycles after the mul_valid cycle.
REQ-009 busy SHALL be 1 in ISSUE, WAIT and WRITE.
REQ-010 req_ready SHALL be 0 outside IDLE; a req_valid that arrives then SHALL be ignored, and the CPU holds it.
REQ-011 rd_req or wr_en while busy=1 SHALL assert stall=1 combinationally; the access SHALL NOT be performed.
REQ-012 A read in IDLE SHALL give rd_data on the next cycle.
REQ-013 A write in IDLE SHALL update the selected register on that edge.
REQ-014 rd_req and wr_en together with the same select SHALL return the old value, with the write taking effect.
REQ-015 mul_valid outside WAIT SHALL be ignored.
REQ-016 rd_req coinciding with the WRITE state SHALL stall that cycle and return the new value on the following read.
REQ-017 req_valid with rd_req in IDLE: the read SHALL complete with pre-multiply data, and the request SHALL be accepted in the same cycle.

Reset
REQ-018 While RST=1 on a clock edge, the block SHALL go to IDLE and clear HI, LO, mul_a, mul_b, rd_data and err to 0.
REQ-019 Reset values SHALL be: mul_start=0, mul_abort=0, busy=0, stall=0; req_ready=1 on the first cycle after reset.
REQ-020 Reset during ISSUE or WAIT SHALL discard the operation; a mul_valid arriving after reset SHALL be ignored.

Configuration
REQ-021 With MUL_TIMEOUT_EN defined, a 7-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-022 With MUL_TIMEOUT_EN defined, if the count reaches 64 without mul_valid, the block SHALL pulse mul_abort for one cycle, set err=1 (sticky until RST), leave HI/LO unchanged and go to IDLE.
REQ-023 With MUL_TIMEOUT_EN defined, mul_valid in the same cycle as expiry SHALL win: normal WRITE, no abort.
REQ-024 Without MUL_TIMEOUT_EN, WAIT SHALL have no bound, and err and mul_abort SHALL be tied to 0.

Structure
REQ-025 The shared package muldiv_pkg SHALL hold the state encoding, TIMEOUT_CYCLES=64, and the HI/LO select constants.
REQ-026 The HI/LO storage and read/write port SHALL be a sub-module, hilo_regfile.

Verification
REQ-027 The bench SHALL cover these scenarios:
- Reset, then req_valid with op_a=7, op_b=-3; mul_valid with product=-21 three cycles later -> mul_start at cycle 1; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy falls after WRITE.
- rd_req with rd_sel=1 during WAIT -> stall=1 until WRITE completes; the retried read returns the new HI.
- In IDLE, wr_en with wr_sel=0 and wr_data=0x1234, then rd_req with rd_sel=0 -> rd_data=0x00001234 one cycle later.
- Second req_valid during WAIT -> req_ready=0 and no second mul_start; accepted once back in IDLE.
- With MUL_TIMEOUT_EN defined and no mul_valid -> mul_abort pulse 64 cycles into WAIT, err=1, HI/LO unchanged; a later mul_valid is ignored.
- RST asserted mid-WAIT, then mul_valid=1 with product=0x5 -> HI=LO=0, state IDLE, busy=0.
